// File: rtl/bn_channel_sequencer.sv
// -----------------------------------------------------------------------------
// bn_channel_sequencer
//
// Upstream control stage for the FP32 batch-normalization element. It holds
// four parameter banks (gamma, beta, moving mean, denominator) of CHANNELS
// words each. It accepts a channel-interleaved pixel stream and presents every
// beat, together with its channel's parameters, to the element. The element's
// fixed-latency result is re-timed into a valid-qualified output stream with a
// frame-end marker. No arithmetic is done here; FP words pass bit-exact.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   param_we/sel/addr/data    parameter write (honoured only while idle)
//                             sel: 0 gamma, 1 beta, 2 mean, 3 denominator
//   start_i                   begin a frame (ignored unless idle)
//   busy_o, done_o            frame in progress / one-cycle end-of-frame pulse
//   s_valid_i/s_ready_o/s_data_i   input beat stream (one channel per beat)
//   data_o, gamma_o, beta_o, mean_o, denom_o   registered element operands
//   result_i                  element result, PIPE_LATENCY cycles after operands
//   m_valid_o/m_data_o/m_last_o    output stream, no backpressure
// -----------------------------------------------------------------------------
module bn_channel_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int CHANNELS     = 8,
  parameter int PIXELS       = 16,
  parameter int PIPE_LATENCY = 2,
  parameter int CW           = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  param_we,
  input  logic [1:0]            param_sel,
  input  logic [CW-1:0]         param_addr,
  input  logic [DATA_WIDTH-1:0] param_data,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] gamma_o,
  output logic [DATA_WIDTH-1:0] beta_o,
  output logic [DATA_WIDTH-1:0] mean_o,
  output logic [DATA_WIDTH-1:0] denom_o,
  input  logic [DATA_WIDTH-1:0] result_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int            PW       = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_nx;
  logic [DATA_WIDTH-1:0]   bank [4][CHANNELS];
  logic [CW-1:0]           ch_cnt;
  logic [PW-1:0]           pix_cnt;
  logic                    accept;
  logic                    last_beat;
  logic [PIPE_LATENCY:0]   pipe_valid;
  logic [PIPE_LATENCY:0]   pipe_last;

  assign accept    = s_valid_i && (state == S_RUN);
  assign last_beat = accept && (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    s_ready_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state)
      S_IDLE: if (start_i) state_nx = S_RUN;
      S_RUN: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (last_beat) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        // Leave once the frame's final beat is on the output.
        if (m_valid_o && m_last_o) state_nx = S_DONE;
      end
      S_DONE: begin
        busy_o   = 1'b1;
        done_o   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Channel / pixel position of the next beat to be accepted.
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start_i)) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
    end else if (accept) begin
      if (ch_cnt == CH_LAST) begin
        ch_cnt  <= '0;
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // NOTE: the parameter file is a small register array that must read as
  // zero after reset, so it is reset explicitly rather than left as RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < CHANNELS; c++)
          bank[b][c] <= '0;
    end else if (param_we && state == S_IDLE && int'(param_addr) < CHANNELS) begin
      bank[param_sel][param_addr] <= param_data;
    end
  end

  // Operand stage: hold until the next accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      gamma_o <= '0;
      beta_o  <= '0;
      mean_o  <= '0;
      denom_o <= '0;
    end else if (accept) begin
      data_o  <= s_data_i;
      gamma_o <= bank[0][ch_cnt];
      beta_o  <= bank[1][ch_cnt];
      mean_o  <= bank[2][ch_cnt];
      denom_o <= bank[3][ch_cnt];
    end
  end

  // {valid,last} tracker. Stage 0 is aligned with the operand registers, so
  // stage PIPE_LATENCY is aligned with result_i; the output registers add the
  // final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
      m_data_o   <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_last[0]  <= last_beat;
      for (int k = 1; k <= PIPE_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_last[k]  <= pipe_last[k-1];
      end
      m_valid_o <= pipe_valid[PIPE_LATENCY];
      m_last_o  <= pipe_valid[PIPE_LATENCY] && pipe_last[PIPE_LATENCY];
      if (pipe_valid[PIPE_LATENCY]) m_data_o <= result_i;
    end
  end

endmodule

// File: tb/tb_bn_channel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bn_channel_sequencer
//
// Drives bn_channel_sequencer with randomized FP32 streams. A behavioural
// stand-in for the batch-norm element computes (x-mean)*gamma/denom+beta from
// the DUT's operands. Expected outputs come from a shadow copy of the
// parameter file and the driven input stream.
// -----------------------------------------------------------------------------
module tb_bn_channel_sequencer;

  localparam int DW  = 32;
  localparam int CH  = 8;
  localparam int PIX = 16;
  localparam int PL  = 2;
  localparam int CW  = 3;
  localparam int N   = CH * PIX;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          param_we;
  logic [1:0]    param_sel;
  logic [CW-1:0] param_addr;
  logic [DW-1:0] param_data;
  logic          start_i;
  logic          busy_o, done_o;
  logic          s_valid_i, s_ready_o;
  logic [DW-1:0] s_data_i;
  logic [DW-1:0] data_o, gamma_o, beta_o, mean_o, denom_o;
  logic [DW-1:0] result_i;
  logic          m_valid_o, m_last_o;
  logic [DW-1:0] m_data_o;

  always #5 clk = ~clk;

  bn_channel_sequencer #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .PIXELS(PIX), .PIPE_LATENCY(PL), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .param_we(param_we), .param_sel(param_sel), .param_addr(param_addr),
    .param_data(param_data),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .data_o(data_o), .gamma_o(gamma_o), .beta_o(beta_o), .mean_o(mean_o),
    .denom_o(denom_o), .result_i(result_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o)
  );

  // ---------------- FP32 helpers (normal numbers, zero, inf/NaN) -----------
  function automatic real fp_to_real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
    e = e - 896;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] elem(input logic [31:0] x, g, b, m, d);
    return real_to_fp((fp_to_real(x) - fp_to_real(m)) * fp_to_real(g) / fp_to_real(d)
                      + fp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  // ---------------- element stand-in: PL register stages --------------------
  logic [31:0] el_pipe [PL];
  always @(posedge clk) begin
    el_pipe[0] <= elem(data_o, gamma_o, beta_o, mean_o, denom_o);
    for (int k = 1; k < PL; k++) el_pipe[k] <= el_pipe[k-1];
  end
  assign result_i = el_pipe[PL-1];

  // ---------------- cycle counter and output monitor ------------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_data[$], obs_data[$];
  bit          exp_last[$], obs_last[$];
  int          exp_cyc[$],  obs_cyc[$], done_cyc[$];
  logic [31:0] shadow [4][CH];
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(negedge clk) begin
    if (m_valid_o === 1'b1) begin
      obs_data.push_back(m_data_o);
      obs_last.push_back(m_last_o);
      obs_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) done_cyc.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic write_param(input logic [1:0] sel, input int addr, input logic [31:0] val);
    @(posedge clk); #1;
    param_we = 1'b1; param_sel = sel; param_addr = CW'(addr); param_data = val;
    @(posedge clk); #1;
    param_we = 1'b0;
    shadow[sel][addr] = val;
  endtask

  task automatic set_identity();
    for (int c = 0; c < CH; c++) begin
      write_param(2'd0, c, FP_ONE);
      write_param(2'd1, c, 32'h0);
      write_param(2'd2, c, 32'h0);
      write_param(2'd3, c, FP_ONE);
    end
  endtask

  // One frame. gap: valid every gap-th cycle. Pokes inject ignored start /
  // param writes; param_on_start writes gamma[0]=2.0 in the start cycle;
  // rst_beat >= 0 aborts with a reset before that beat.
  task automatic run_frame(input int gap, input bit fixed_one, input bit start_poke,
                           input bit param_poke, input bit param_on_start,
                           input int rst_beat, output int start_c,
                           output int ready_bad, output logic [31:0] last_x);
    int b, slot, ch;
    logic [31:0] x;
    exp_data.delete(); exp_last.delete(); exp_cyc.delete();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete(); done_cyc.delete();
    ready_bad = 0; last_x = '0;
    @(posedge clk); #1;
    start_i = 1'b1; start_c = cyc;
    if (param_on_start) begin
      param_we = 1'b1; param_sel = 2'd0; param_addr = '0; param_data = FP_TWO;
      shadow[0][0] = FP_TWO;
    end
    @(posedge clk); #1;
    start_i = 1'b0; param_we = 1'b0;
    b = 0; slot = 0;
    while (b < N) begin
      if (b == rst_beat) begin
        rst = 1'b1; s_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (s_ready_o !== 1'b1) ready_bad++;
      s_valid_i = ((slot % gap) == 0);
      if (s_valid_i) begin
        x = fixed_one ? FP_ONE : rand_fp();
        s_data_i = x; last_x = x;
        ch = b % CH;
        exp_data.push_back(elem(x, shadow[0][ch], shadow[1][ch], shadow[2][ch], shadow[3][ch]));
        exp_last.push_back(b == N - 1);
        exp_cyc.push_back(cyc + PL + 2);
        b++;
      end else begin
        s_data_i = $urandom;
      end
      if (start_poke && slot == 20) start_i = 1'b1;
      if (param_poke && slot == 15) begin
        param_we = 1'b1; param_sel = 2'd0; param_addr = '0; param_data = FP_TWO;
      end
      slot++;
      @(posedge clk); #1;
      start_i = 1'b0; param_we = 1'b0;
    end
    s_valid_i = 1'b0;
    if (start_poke) begin
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    for (int i = 0; i < 60 && done_cyc.size() == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, s_ready_o, m_valid_o, m_last_o} !== 5'b0)
      $display("FAIL reset_ctrl got=%b want=00000", {busy_o, done_o, s_ready_o, m_valid_o, m_last_o});
    else n_pass++;
    n_checks++;
    if (m_data_o !== 32'h0) $display("FAIL reset_m_data got=%h want=0", m_data_o);
    else n_pass++;
    n_checks++;
    if ({data_o, gamma_o, beta_o, mean_o, denom_o} !== 160'h0)
      $display("FAIL reset_operands got=%h want=0", {data_o, gamma_o, beta_o, mean_o, denom_o});
    else n_pass++;
    rst = 1'b0;
    for (int b = 0; b < 4; b++) for (int c = 0; c < CH; c++) shadow[b][c] = '0;
  endtask

  task automatic test_identity();
    int sc, rb; logic [31:0] lx;
    set_identity();
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, sc, rb, lx);
    n_checks++;
    if (obs_data.size() != N) $display("FAIL ident_count got=%0d want=%0d", obs_data.size(), N);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_cyc[i] != exp_cyc[i])
        $display("FAIL ident_beat%0d got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                 i, obs_data[i], obs_last[i], obs_cyc[i], exp_data[i], exp_last[i], exp_cyc[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - sc != N + PL + 3)
      $display("FAIL ident_done_timing got count=%0d delta=%0d want count=1 delta=%0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - sc : -1, N + PL + 3);
    else n_pass++;
    n_checks++;
    if (rb != 0) $display("FAIL ident_ready got=%0d low cycles want=0", rb);
    else n_pass++;
    n_checks++;
    if (data_o !== lx) $display("FAIL ident_operand_hold got=%h want=%h", data_o, lx);
    else n_pass++;
  endtask

  task automatic test_channel_map();
    int sc, rb; logic [31:0] lx;
    for (int c = 0; c < CH; c++) write_param(2'd0, c, real_to_fp(real'(c)));
    run_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, -1, sc, rb, lx);
    n_checks++;
    if (obs_data.size() != N) $display("FAIL chmap_count got=%0d want=%0d", obs_data.size(), N);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        $display("FAIL chmap_beat%0d got data=%h last=%b want data=%h last=%b",
                 i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_data.size() < 9 || obs_data[7] !== 32'h40E0_0000 || obs_data[8] !== 32'h0)
      $display("FAIL chmap_wrap got ch7=%h next=%h want ch7=40e00000 next=00000000",
               (obs_data.size() > 7) ? obs_data[7] : 32'hx, (obs_data.size() > 8) ? obs_data[8] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_throttle();
    int sc, rb; logic [31:0] lx;
    set_identity();
    run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0, -1, sc, rb, lx);
    n_checks++;
    if (obs_data.size() != N || done_cyc.size() != 1)
      $display("FAIL thr_count got beats=%0d done=%0d want beats=%0d done=1",
               obs_data.size(), done_cyc.size(), N);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_cyc[i] != exp_cyc[i])
        $display("FAIL thr_beat%0d got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                 i, obs_data[i], obs_last[i], obs_cyc[i], exp_data[i], exp_last[i], exp_cyc[i]);
      else n_pass++;
    end
  endtask

  // A write during RUN must be dropped; the same write in the start cycle sticks.
  task automatic test_param_write();
    int sc, rb; logic [31:0] lx;
    for (int pass = 0; pass < 2; pass++) begin
      run_frame(1, 1'b0, 1'b0, pass == 0, pass == 1, -1, sc, rb, lx);
      n_checks++;
      if (obs_data.size() != N) $display("FAIL param%0d_count got=%0d want=%0d", pass, obs_data.size(), N);
      else n_pass++;
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
        n_checks++;
        if (obs_data[i] !== exp_data[i])
          $display("FAIL param%0d_beat%0d got=%h want=%h", pass, i, obs_data[i], exp_data[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_start_ignored();
    int sc, rb; logic [31:0] lx;
    run_frame(1, 1'b0, 1'b1, 1'b0, 1'b0, -1, sc, rb, lx);
    n_checks++;
    if (obs_data.size() != N || done_cyc.size() != 1)
      $display("FAIL start_ign_count got beats=%0d done=%0d want beats=%0d done=1",
               obs_data.size(), done_cyc.size(), N);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        $display("FAIL start_ign_beat%0d got data=%h last=%b want data=%h last=%b",
                 i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++;
    if ({busy_o, s_ready_o} !== 2'b00) $display("FAIL start_ign_idle got busy,ready=%b want=00", {busy_o, s_ready_o});
    else n_pass++;
  endtask

  task automatic test_idle_ignore();
    int rb = 0;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1; s_data_i = $urandom;
      @(posedge clk); #1;
      if (s_ready_o !== 1'b0) rb++;
    end
    s_valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (rb != 0 || obs_data.size() != 0)
      $display("FAIL idle_ignore got ready_high=%0d beats=%0d want 0 and 0", rb, obs_data.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int sc, rb, snap; logic [31:0] lx;
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 50, sc, rb, lx);
    n_checks++;
    if ({busy_o, done_o, s_ready_o, m_valid_o, m_last_o} !== 5'b0 || m_data_o !== 32'h0 ||
        {data_o, gamma_o, beta_o, mean_o, denom_o} !== 160'h0)
      $display("FAIL rstmid_outputs got ctrl=%b m_data=%h data=%h gamma=%h want all 0",
               {busy_o, done_o, s_ready_o, m_valid_o, m_last_o}, m_data_o, data_o, gamma_o);
    else n_pass++;
    for (int b = 0; b < 4; b++) for (int c = 0; c < CH; c++) shadow[b][c] = '0;
    snap = obs_data.size();
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (obs_data.size() != snap || done_cyc.size() != 0)
      $display("FAIL rstmid_quiet got new_beats=%0d done=%0d want 0 and 0",
               obs_data.size() - snap, done_cyc.size());
    else n_pass++;
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, sc, rb, lx);
    n_checks++;
    if (obs_data.size() != N || done_cyc.size() != 1 || done_cyc[0] - sc != N + PL + 3)
      $display("FAIL rstmid_refill got beats=%0d done=%0d want beats=%0d done=1 at +%0d",
               obs_data.size(), done_cyc.size(), N, N + PL + 3);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        $display("FAIL rstmid_beat%0d got data=%h last=%b want data=%h last=%b",
                 i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++;
    if ({gamma_o, beta_o, mean_o, denom_o} !== 128'h0 || data_o !== lx)
      $display("FAIL rstmid_params got gamma=%h denom=%h data=%h want 0, 0, %h",
               gamma_o, denom_o, data_o, lx);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; param_we = 1'b0; param_sel = '0; param_addr = '0; param_data = '0;
    start_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    test_reset();
    test_identity();
    test_channel_map();
    test_throttle();
    test_param_write();
    test_start_ignored();
    test_idle_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
